// File: rtl/wr_ptr_full_if.sv
// wr_ptr_full_if: write-side pointer/flag bundle between producer and FIFO write logic
interface wr_ptr_full_if #(parameter int ADDR_SIZE = 4);
  logic                 wr_inc;
  logic [ADDR_SIZE:0]   rd_ptr_sync;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE:0]   wr_ptr;
  logic                 wr_full;
  logic                 wr_almost_full;
  logic [ADDR_SIZE:0]   wr_count;
  logic                 wr_overflow;
  modport master (
    output wr_inc, rd_ptr_sync,
    input  wr_addr, wr_ptr, wr_full, wr_almost_full, wr_count, wr_overflow
  );
  modport slave (
    input  wr_inc, rd_ptr_sync,
    output wr_addr, wr_ptr, wr_full, wr_almost_full, wr_count, wr_overflow
  );
endinterface

// File: rtl/wr_ptr_full.sv
// wr_ptr_full: async FIFO write pointer, Gray pointer export, full/almost-full/count/overflow
module wr_ptr_full #(
  parameter int ADDR_SIZE = 4,
  parameter int AF_MARGIN = 2
) (
  input logic          wr_clk,
  input logic          wr_rst,
  wr_ptr_full_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] AF_TH = (ADDR_SIZE + 1)'(DEPTH - AF_MARGIN);
  logic [ADDR_SIZE:0] wbin, wbin_next, gray_next, rbin, used_next;
  logic accept;
  for (genvar i = 0; i <= ADDR_SIZE; i++) begin : g_rbin
    assign rbin[i] = ^bus.rd_ptr_sync[ADDR_SIZE:i];
  end
  assign accept    = bus.wr_inc & ~bus.wr_full;
  assign wbin_next = wbin + {{ADDR_SIZE{1'b0}}, accept};
  assign gray_next = wbin_next ^ (wbin_next >> 1);
  assign used_next = wbin_next - rbin;
  assign bus.wr_addr = wbin[ADDR_SIZE-1:0];
  // full when write pointer is one lap ahead: top two Gray bits inverted, rest equal
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wbin               <= '0;
      bus.wr_ptr         <= '0;
      bus.wr_full        <= 1'b0;
      bus.wr_almost_full <= 1'b0;
      bus.wr_count       <= '0;
      bus.wr_overflow    <= 1'b0;
    end else begin
      wbin               <= wbin_next;
      bus.wr_ptr         <= gray_next;
      bus.wr_full        <= gray_next == {~bus.rd_ptr_sync[ADDR_SIZE:ADDR_SIZE-1], bus.rd_ptr_sync[ADDR_SIZE-2:0]};
      bus.wr_almost_full <= used_next >= AF_TH;
      bus.wr_count       <= used_next;
      bus.wr_overflow    <= bus.wr_overflow | (bus.wr_inc & bus.wr_full);
    end
  end
endmodule

// File: tb/tb_wr_ptr_full.sv
// tb_wr_ptr_full: random + directed stimulus; model tracks total writes/reads as plain integers
module tb_wr_ptr_full;
  localparam int DEPTH = 16;
  typedef struct {
    logic [4:0] ptr;
    logic [4:0] cnt;
    logic [3:0] addr;
    logic       full;
    logic       af;
    logic       ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  wr_ptr_full_if #(.ADDR_SIZE(4)) bus ();
  wr_ptr_full #(.ADDR_SIZE(4), .AF_MARGIN(2)) dut (.wr_clk(clk), .wr_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int wn = 0;
  int rn = 0;
  logic full_m = 1'b0;
  logic ovf_m = 1'b0;
  exp_t q[$];
  function automatic logic [4:0] gray(int v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(logic inc, int rd_total, logic r);
    exp_t e;
    int cnt;
    rn = rd_total;
    bus.wr_inc = inc;
    bus.rd_ptr_sync = gray(rn);
    rst = r;
    @(posedge clk);
    if (r) begin
      wn = 0;
      full_m = 1'b0;
      ovf_m = 1'b0;
      cnt = 0;
    end else begin
      if (inc && full_m) ovf_m = 1'b1;
      if (inc && !full_m) wn++;
      cnt = wn - rn;
      full_m = cnt == DEPTH;
    end
    e.ptr = gray(wn);
    e.cnt = 5'(cnt);
    e.addr = 4'(wn % DEPTH);
    e.full = full_m;
    e.af = cnt >= DEPTH - 2;
    e.ovf = ovf_m;
    q.push_back(e);
    #1;
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("wr_ptr", int'(bus.wr_ptr), int'(e.ptr));
      chk("wr_count", int'(bus.wr_count), int'(e.cnt));
      chk("wr_addr", int'(bus.wr_addr), int'(e.addr));
      chk("wr_full", int'(bus.wr_full), int'(e.full));
      chk("wr_almost_full", int'(bus.wr_almost_full), int'(e.af));
      chk("wr_overflow", int'(bus.wr_overflow), int'(e.ovf));
    end
  end
  initial begin
    bus.wr_inc = 1'b0;
    bus.rd_ptr_sync = '0;
    step(1'b1, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("idle_addr", int'(bus.wr_addr), 0);
    chk("idle_count", int'(bus.wr_count), 0);
    for (int i = 0; i < 16; i++) begin
      chk("fill_addr", int'(bus.wr_addr), i);
      step(1'b1, 0, 1'b0);
      chk("fill_af", int'(bus.wr_almost_full), int'(i >= 13));
    end
    chk("full_ptr", int'(bus.wr_ptr), 5'b11000);
    chk("full_count", int'(bus.wr_count), 16);
    chk("full_flag", int'(bus.wr_full), 1);
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b0);
    chk("ovf_ptr", int'(bus.wr_ptr), 5'b11000);
    chk("ovf_count", int'(bus.wr_count), 16);
    step(1'b0, 0, 1'b0);
    chk("ovf_sticky", int'(bus.wr_overflow), 1);
    step(1'b0, 1, 1'b0);
    chk("drain_full", int'(bus.wr_full), 0);
    chk("drain_count", int'(bus.wr_count), 15);
    chk("drain_af", int'(bus.wr_almost_full), 1);
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, wn, 1'b0);
      if (i == 30) chk("wrap_ptr_31", int'(bus.wr_ptr), 5'b10000);
      chk("wrap_count", int'(bus.wr_count), 1);
      chk("wrap_full", int'(bus.wr_full), 0);
    end
    chk("wrap_ptr_0", int'(bus.wr_ptr), 0);
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 0, 1'b0);
    chk("pre_rst_addr", int'(bus.wr_addr), 7);
    step(1'b1, 0, 1'b1);
    chk("rst_count", int'(bus.wr_count), 0);
    chk("rst_addr", int'(bus.wr_addr), 0);
    step(1'b1, 0, 1'b0);
    chk("post_rst_addr", int'(bus.wr_addr), 1);
    for (int i = 0; i < 600; i++) begin
      logic r;
      logic inc;
      int rd;
      r = $urandom_range(0, 99) == 0;
      inc = $urandom_range(0, 99) < 65;
      rd = r ? 0 : rn + int'(rn < wn && $urandom_range(0, 1) == 1);
      step(inc, rd, r);
    end
    step(1'b0, rn, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
